// File: rtl/sie_defs_pkg.sv
// sie_defs_pkg: USB PID nibble constants shared by the SIE and protocol engine
package sie_defs_pkg;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
endpackage

// File: rtl/usb_pe_pkg.sv
// usb_pe_pkg: protocol engine types shared by the TX and RX halves
package usb_pe_pkg;
  typedef enum logic [1:0] {IDLE, SEND_PID, SEND_PAYLOAD, AWAIT_RESULT} PeTxState;
endpackage

// File: rtl/usb_pe_tx.sv
// usb_pe_tx: sends handshake or DATA0/1 packets to the SIE and settles the IN FIFO transaction
module usb_pe_tx
  import sie_defs_pkg::*;
  import usb_pe_pkg::*;
#(
  parameter int EP_DATA_WID = 8,
  parameter int MPS_WID     = 7
) (
  input  logic                   clk48,
  input  logic                   rst_n,
  input  logic                   sendReq,
  input  logic                   sendData,
  input  logic [3:0]             handshakePid,
  input  logic                   dataToggle,
  input  logic [MPS_WID-1:0]     maxPacketSize,
  input  logic                   hostAck,
  input  logic                   hostTimeout,
  output logic                   sendBusy,
  output logic                   sendDone,
  output logic [MPS_WID-1:0]     sentBytes,
  input  logic                   fifoDataAvailable,
  input  logic [EP_DATA_WID-1:0] fifoData,
  output logic                   fifoPop,
  output logic                   fifoPopTransDone,
  output logic                   fifoPopTransSuccess,
  output logic                   txReqSendPacket,
  output logic                   txDataValid,
  output logic                   txIsLastByte,
  output logic [7:0]             txData,
  input  logic                   txAcceptNewData
);
  PeTxState state_q, state_d;
  logic [3:0] pid_q, pid_d;
  logic is_data_q, is_data_d;
  logic has_pl_q, has_pl_d;
  logic [EP_DATA_WID-1:0] buf_q, buf_d;
  logic [MPS_WID-1:0] cnt_q, cnt_d, sent_q, sent_d;
  logic pl_last;
  assign sendBusy  = state_q != IDLE;
  assign sentBytes = sent_q;
  assign pl_last   = (cnt_q == maxPacketSize - MPS_WID'(1)) || !fifoDataAvailable;
  // State and datapath registers; reset drops any packet in flight without a FIFO pulse
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pid_q     <= '0;
      is_data_q <= 1'b0;
      has_pl_q  <= 1'b0;
      buf_q     <= '0;
      cnt_q     <= '0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      is_data_q <= is_data_d;
      has_pl_q  <= has_pl_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      sent_q    <= sent_d;
    end
  end
  // Next state and outputs; the first payload word is prefetched while leaving IDLE
  always_comb begin
    state_d             = state_q;
    pid_d               = pid_q;
    is_data_d           = is_data_q;
    has_pl_d            = has_pl_q;
    buf_d               = buf_q;
    cnt_d               = cnt_q;
    sent_d              = sent_q;
    sendDone            = 1'b0;
    fifoPop             = 1'b0;
    fifoPopTransDone    = 1'b0;
    fifoPopTransSuccess = 1'b0;
    txReqSendPacket     = 1'b0;
    txDataValid         = 1'b0;
    txIsLastByte        = 1'b0;
    txData              = 8'h00;
    case (state_q)
      IDLE: if (sendReq) begin
        pid_d     = sendData ? (dataToggle ? PID_DATA1 : PID_DATA0) : handshakePid;
        is_data_d = sendData;
        has_pl_d  = sendData && maxPacketSize != '0 && fifoDataAvailable;
        fifoPop   = has_pl_d;
        buf_d     = has_pl_d ? fifoData : buf_q;
        cnt_d     = '0;
        state_d   = SEND_PID;
      end
      SEND_PID: begin
        txReqSendPacket = 1'b1;
        txDataValid     = 1'b1;
        txIsLastByte    = !has_pl_q;
        txData          = {~pid_q, pid_q};
        if (txAcceptNewData) begin
          sendDone = !is_data_q;
          sent_d   = (is_data_q && !has_pl_q) ? '0 : sent_q;
          state_d  = !is_data_q ? IDLE : (has_pl_q ? SEND_PAYLOAD : AWAIT_RESULT);
        end
      end
      SEND_PAYLOAD: begin
        txReqSendPacket = 1'b1;
        txDataValid     = 1'b1;
        txIsLastByte    = pl_last;
        txData          = buf_q;
        if (txAcceptNewData) begin
          fifoPop = !pl_last;
          buf_d   = pl_last ? buf_q : fifoData;
          cnt_d   = pl_last ? cnt_q : cnt_q + MPS_WID'(1);
          sent_d  = pl_last ? cnt_q + MPS_WID'(1) : sent_q;
          state_d = pl_last ? AWAIT_RESULT : SEND_PAYLOAD;
        end
      end
      AWAIT_RESULT: if (hostAck || hostTimeout) begin
        fifoPopTransDone    = 1'b1;
        fifoPopTransSuccess = hostAck;
        sendDone            = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_usb_pe_tx.sv
// tb_usb_pe_tx: table-driven packet vectors checked against a byte scoreboard
module tb_usb_pe_tx;
  logic clk48 = 1'b0, rst_n = 1'b0;
  logic sendReq = 0, sendData = 0, dataToggle = 0, hostAck = 0, hostTimeout = 0;
  logic [3:0] handshakePid = '0;
  logic [6:0] maxPacketSize = '0;
  logic sendBusy, sendDone, fifoPop, fifoPopTransDone, fifoPopTransSuccess;
  logic [6:0] sentBytes;
  logic fifoDataAvailable = 0, txAcceptNewData = 1;
  logic [7:0] fifoData = '0, txData;
  logic txReqSendPacket, txDataValid, txIsLastByte;
  typedef struct {
    logic sd; logic [3:0] hp; logic tog; logic [6:0] mps; int n; int res; bit stall;
    logic [7:0] pid; logic [6:0] sent; int remain; } vec_t;
  vec_t vt[10];
  logic [8:0] exp_q[$];
  logic [7:0] fifo[$];
  int vecs = 0, errs = 0;
  bit done_seen, td_seen, td_succ, held_v;
  logic [8:0] held;
  always #5 clk48 = ~clk48;
  usb_pe_tx dut (.clk48(clk48), .rst_n(rst_n), .sendReq(sendReq), .sendData(sendData),
    .handshakePid(handshakePid), .dataToggle(dataToggle), .maxPacketSize(maxPacketSize),
    .hostAck(hostAck), .hostTimeout(hostTimeout), .sendBusy(sendBusy), .sendDone(sendDone),
    .sentBytes(sentBytes), .fifoDataAvailable(fifoDataAvailable), .fifoData(fifoData),
    .fifoPop(fifoPop), .fifoPopTransDone(fifoPopTransDone),
    .fifoPopTransSuccess(fifoPopTransSuccess), .txReqSendPacket(txReqSendPacket),
    .txDataValid(txDataValid), .txIsLastByte(txIsLastByte), .txData(txData),
    .txAcceptNewData(txAcceptNewData));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask
  task automatic drive_fifo();
    fifoDataAvailable = fifo.size() != 0;
    fifoData = fifo.size() != 0 ? fifo[0] : 8'h00;
  endtask
  task automatic tick();
    bit pop;
    @(negedge clk48);
    pop = fifoPop;
    if (held_v) chk("stall_hold", {txData, txIsLastByte}, held);
    held_v = txDataValid && !txAcceptNewData;
    held = {txData, txIsLastByte};
    if (txDataValid && txAcceptNewData) begin
      if (exp_q.size() == 0) fail("extra_byte");
      else chk("tx_byte", {txData, txIsLastByte}, exp_q.pop_front());
    end
    if (fifoPop && fifoPopTransDone) fail("pop_with_transdone");
    if (fifoPop && fifo.size() == 0) fail("pop_empty");
    if (sendDone) done_seen = 1;
    if (fifoPopTransDone) begin
      td_seen = 1;
      td_succ = fifoPopTransSuccess;
    end
    @(posedge clk48);
    #1;
    if (pop && fifo.size() != 0) void'(fifo.pop_front());
    drive_fifo();
  endtask
  task automatic run(input vec_t v, input int idx);
    int m;
    fifo.delete();
    for (int k = 0; k < v.n; k++) fifo.push_back(8'h11 * (k + 1));
    drive_fifo();
    m = v.sd ? (v.n < int'(v.mps) ? v.n : int'(v.mps)) : 0;
    exp_q.push_back({v.pid, m == 0});
    for (int k = 0; k < m; k++) exp_q.push_back({fifo[k], k == m - 1});
    done_seen = 0;
    td_seen = 0;
    sendData = v.sd; handshakePid = v.hp; dataToggle = v.tog; maxPacketSize = v.mps;
    txAcceptNewData = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
    sendReq = 1;
    tick();
    sendReq = 0;
    chk($sformatf("busy_v%0d", idx), sendBusy, 1);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      if (v.stall) txAcceptNewData = 1'($urandom_range(0, 1));
      sendReq = v.stall && c == 2;
      hostAck = v.stall && c == 3;
      tick();
    end
    sendReq = 0;
    hostAck = 0;
    txAcceptNewData = 1;
    if (exp_q.size() != 0) begin
      fail($sformatf("byte_timeout_v%0d", idx));
      exp_q.delete();
    end
    if (v.sd) begin
      chk($sformatf("early_done_v%0d", idx), done_seen, 0);
      hostAck = v.res != 1;
      hostTimeout = v.res != 0;
      tick();
      hostAck = 0;
      hostTimeout = 0;
      chk($sformatf("transdone_v%0d", idx), td_seen, 1);
      chk($sformatf("success_v%0d", idx), td_succ, v.res != 1);
      chk($sformatf("sentbytes_v%0d", idx), sentBytes, v.sent);
    end else chk($sformatf("hs_no_transdone_v%0d", idx), td_seen, 0);
    chk($sformatf("done_v%0d", idx), done_seen, 1);
    chk($sformatf("idle_v%0d", idx), sendBusy, 0);
    chk($sformatf("remain_v%0d", idx), fifo.size(), v.remain);
  endtask
  initial begin
    vt[0] = '{0, 4'b0010, 0, 64, 2, 0, 0, 8'hD2, 0, 2};
    vt[1] = '{1, 4'b0000, 1, 64, 3, 0, 0, 8'h4B, 3, 0};
    vt[2] = '{1, 4'b0000, 0, 8, 10, 0, 0, 8'hC3, 8, 2};
    vt[3] = '{1, 4'b0000, 0, 64, 0, 1, 0, 8'hC3, 0, 0};
    vt[4] = '{1, 4'b0000, 1, 64, 3, 0, 1, 8'h4B, 3, 0};
    vt[5] = '{1, 4'b0000, 1, 4, 4, 2, 0, 8'h4B, 4, 0};
    vt[6] = '{1, 4'b0000, 0, 0, 5, 1, 0, 8'hC3, 0, 5};
    vt[7] = '{1, 4'b0000, 1, 1, 3, 0, 1, 8'h4B, 1, 2};
    vt[8] = '{0, 4'b1010, 1, 64, 0, 0, 0, 8'h5A, 0, 0};
    vt[9] = '{0, 4'b1110, 0, 64, 1, 0, 0, 8'h1E, 0, 1};
    tick();
    tick();
    chk("reset_outputs", {sendBusy, sendDone, sentBytes, fifoPop, fifoPopTransDone,
      fifoPopTransSuccess, txReqSendPacket, txDataValid, txIsLastByte, txData}, 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 10; i++) run(vt[i], i);
    fifo.delete();
    for (int k = 0; k < 3; k++) fifo.push_back(8'h11 * (k + 1));
    drive_fifo();
    exp_q = '{{8'h4B, 1'b0}, {8'h11, 1'b0}, {8'h22, 1'b0}, {8'h33, 1'b1}};
    td_seen = 0;
    sendData = 1; dataToggle = 1; maxPacketSize = 64; txAcceptNewData = 1;
    sendReq = 1;
    tick();
    sendReq = 0;
    tick();
    tick();
    chk("rst_at_byte2", {txData, txIsLastByte}, {8'h22, 1'b0});
    rst_n = 0;
    txAcceptNewData = 0;
    tick();
    held_v = 0;
    chk("midpkt_reset_outputs", {sendBusy, sendDone, sentBytes, fifoPop, fifoPopTransDone,
      fifoPopTransSuccess, txReqSendPacket, txDataValid, txIsLastByte, txData}, 0);
    chk("midpkt_reset_no_transdone", td_seen, 0);
    rst_n = 1;
    txAcceptNewData = 1;
    exp_q.delete();
    hostAck = 1;
    tick();
    hostAck = 0;
    chk("post_reset_idle", {sendBusy, fifoPopTransDone, txDataValid}, 0);
    chk("post_reset_no_transdone", td_seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
